// File: rtl/line_capture.sv
// line_capture: captures one complete sensor line into a buffer, then streams
// it out with valid/ready handshaking.
// Optional feature: define LINE_CAPTURE_DARK_SUB_EN to subtract DARK_LEVEL from
// each sample before storage (saturating at zero).
module line_capture #(
    parameter int              NPIX       = 1024,
    parameter int              DW         = 12,
    parameter logic [DW-1:0]   DARK_LEVEL = '0
) (
    input  logic                      FPGA_CLK,
    input  logic                      FPGA_RST,
    input  logic                      EOC_EDGE,
    input  logic                      EOS_EDGE,
    input  logic [DW-1:0]             ADC_DATA,
    input  logic                      ARM,
    output logic                      M_VALID,
    input  logic                      M_READY,
    output logic [DW-1:0]             M_DATA,
    output logic [$clog2(NPIX)-1:0]   M_ADDR,
    output logic                      M_LAST,
    output logic                      BUSY,
    output logic                      OVF,
    output logic [$clog2(NPIX):0]     PIX_COUNT
);

    localparam int          AW       = $clog2(NPIX);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(NPIX);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, READOUT} state_t;

    state_t        state;
    state_t        state_next;

    logic [DW-1:0] line_mem [NPIX];
    logic [DW-1:0] wr_data;
    logic [DW-1:0] ram_q;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   cap_count;
    logic          wr_en;
    logic          rd_adv;
    logic          primed;
    logic          xfer;

`ifdef LINE_CAPTURE_DARK_SUB_EN
    logic [DW:0]   dark_diff;

    // Remove the dark offset; the extra top bit flags underflow, which clamps to zero.
    always_comb begin
        dark_diff = {1'b0, ADC_DATA} - {1'b0, DARK_LEVEL};
        wr_data   = dark_diff[DW] ? '0 : dark_diff[DW-1:0];
    end
`else
    logic          unused_dark_level;

    assign unused_dark_level = ^DARK_LEVEL;
    assign wr_data           = ADC_DATA;
`endif

    // A pixel is stored only while capturing and only while the buffer has room.
    assign wr_en     = (state == CAPTURE) && EOC_EDGE && (wr_ptr < PTR_FULL);
    assign cap_count = wr_ptr + (wr_en ? PTR_ONE : '0);

    // Fetch the next pixel once the read address has settled, when the output slot is free.
    assign rd_adv = (state == READOUT) && primed && (rd_ptr != PIX_COUNT)
                    && (!M_VALID || M_READY);
    assign xfer   = M_VALID && M_READY;

    assign BUSY   = (state != IDLE);
    assign M_DATA = M_VALID ? ram_q : '0;

    // State register; reset abandons whatever line was in progress.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: wait for arm, align to a line boundary, capture, then drain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ARM) state_next = SYNC;
            SYNC:    if (EOS_EDGE) state_next = CAPTURE;
            CAPTURE: if (EOS_EDGE) state_next = (cap_count == '0) ? IDLE : READOUT;
            READOUT: if (xfer && M_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Buffer storage and synchronous read port, left unreset so it maps onto block RAM.
    always_ff @(posedge FPGA_CLK) begin
        if (wr_en)  line_mem[wr_ptr[AW-1:0]] <= wr_data;
        if (rd_adv) ram_q <= line_mem[rd_ptr[AW-1:0]];
    end

    // Capture-side bookkeeping: write pointer, overflow flag and latched line length.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            wr_ptr    <= '0;
            OVF       <= 1'b0;
            PIX_COUNT <= '0;
        end else begin
            if (state == IDLE && ARM) begin
                wr_ptr <= '0;
                OVF    <= 1'b0;
            end
            if (state == CAPTURE && EOC_EDGE) begin
                if (wr_en) wr_ptr <= cap_count;
                else       OVF    <= 1'b1;
            end
            if (state == CAPTURE && EOS_EDGE) PIX_COUNT <= cap_count;
        end
    end

    // Readout-side stream registers; outputs hold while the consumer stalls.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            rd_ptr  <= '0;
            primed  <= 1'b0;
            M_VALID <= 1'b0;
            M_LAST  <= 1'b0;
            M_ADDR  <= '0;
        end else begin
            primed <= (state == READOUT);
            if (state != READOUT) rd_ptr <= '0;
            if (rd_adv) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                M_VALID <= 1'b1;
                M_ADDR  <= rd_ptr[AW-1:0];
                M_LAST  <= ((rd_ptr + PTR_ONE) == PIX_COUNT);
            end else if (xfer) begin
                M_VALID <= 1'b0;
                M_LAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_capture.sv
// tb_line_capture: directed, table-driven bench for line_capture.
// Build with LINE_CAPTURE_DARK_SUB_EN defined to exercise dark-level subtraction.
module tb_line_capture;

    localparam int NPIX = 1024;
    localparam int DW   = 12;
    localparam int AW   = $clog2(NPIX);

    logic          FPGA_CLK;
    logic          FPGA_RST;
    logic          EOC_EDGE;
    logic          EOS_EDGE;
    logic [DW-1:0] ADC_DATA;
    logic          ARM;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic [AW-1:0] M_ADDR;
    logic          M_LAST;
    logic          BUSY;
    logic          OVF;
    logic [AW:0]   PIX_COUNT;

    typedef struct {
        int n;
        bit coinc;
        bit rand_ready;
        int mode;
        int exp_cnt;
        bit exp_ovf;
    } line_vec_t;

    line_vec_t vecs[8];
    int        exp_mem[NPIX];
    int        total;
    int        bad;

    line_capture #(
        .NPIX       (NPIX),
        .DW         (DW),
        .DARK_LEVEL (12'd100)
    ) dut (
        .FPGA_CLK  (FPGA_CLK),
        .FPGA_RST  (FPGA_RST),
        .EOC_EDGE  (EOC_EDGE),
        .EOS_EDGE  (EOS_EDGE),
        .ADC_DATA  (ADC_DATA),
        .ARM       (ARM),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .M_DATA    (M_DATA),
        .M_ADDR    (M_ADDR),
        .M_LAST    (M_LAST),
        .BUSY      (BUSY),
        .OVF       (OVF),
        .PIX_COUNT (PIX_COUNT)
    );

    initial FPGA_CLK = 1'b0;
    always #5 FPGA_CLK = ~FPGA_CLK;

    function automatic int raw_val(input int mode, input int idx);
        case (mode)
            0:       return idx & 12'hFFF;
            1:       return (idx * 37 + 11) & 12'hFFF;
            default: begin
                case (idx)
                    0:       return 50;
                    1:       return 100;
                    default: return 4095;
                endcase
            end
        endcase
    endfunction

    function automatic int stored_value(input int raw);
`ifdef LINE_CAPTURE_DARK_SUB_EN
        return (raw > 100) ? raw - 100 : 0;
`else
        return raw;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Arm, inject a stray pixel in SYNC, open the line, send pixels, close the line.
    task automatic applyStimulus(input line_vec_t v);
        ARM = 1'b1;
        @(negedge FPGA_CLK);
        ARM      = 1'b0;
        EOC_EDGE = 1'b1;
        ADC_DATA = 12'hABC;
        @(negedge FPGA_CLK);
        EOC_EDGE = 1'b0;
        EOS_EDGE = 1'b1;
        @(negedge FPGA_CLK);
        EOS_EDGE = 1'b0;
        checkOutput("busy_capture", int'(BUSY), 1);
        for (int i = 0; i < v.n; i++) begin
            EOC_EDGE = 1'b1;
            ADC_DATA = 12'(raw_val(v.mode, i));
            EOS_EDGE = v.coinc && (i == v.n - 1);
            if (i < NPIX) exp_mem[i] = stored_value(raw_val(v.mode, i));
            @(negedge FPGA_CLK);
            EOC_EDGE = 1'b0;
            EOS_EDGE = 1'b0;
        end
        if (!v.coinc || v.n == 0) begin
            EOS_EDGE = 1'b1;
            @(negedge FPGA_CLK);
            EOS_EDGE = 1'b0;
        end
    endtask

    // Drain the line against the model while injecting sensor noise that must be ignored.
    task automatic runReadout(input line_vec_t v);
        int beat;
        int first_valid;
        bit prev_stall;
        bit done;
        beat        = 0;
        first_valid = -1;
        prev_stall  = 1'b0;
        done        = 1'b0;
        checkOutput("pix_count", int'(PIX_COUNT), v.exp_cnt);
        checkOutput("ovf", int'(OVF), int'(v.exp_ovf));
        if (v.exp_cnt == 0) begin
            checkOutput("empty_busy", int'(BUSY), 0);
            checkOutput("empty_valid", int'(M_VALID), 0);
            return;
        end
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            M_READY  = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            EOC_EDGE = cyc[0];
            EOS_EDGE = ((cyc % 7) == 3);
            ADC_DATA = 12'h5A5;
            if (prev_stall) checkOutput("stall_hold_valid", int'(M_VALID), 1);
            prev_stall = 1'b0;
            if (M_VALID) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    checkOutput("first_valid_latency", cyc, 2);
                end
                checkOutput("beat_data", int'(M_DATA), exp_mem[beat]);
                checkOutput("beat_addr", int'(M_ADDR), beat);
                checkOutput("beat_last", int'(M_LAST), int'(beat == v.exp_cnt - 1));
                if (M_READY) begin
                    beat++;
                    if (M_LAST) done = 1'b1;
                end else begin
                    prev_stall = 1'b1;
                end
            end
            @(negedge FPGA_CLK);
        end
        EOC_EDGE = 1'b0;
        EOS_EDGE = 1'b0;
        M_READY  = 1'b0;
        checkOutput("readout_done", int'(done), 1);
        checkOutput("beat_count", beat, v.exp_cnt);
        checkOutput("valid_after_last", int'(M_VALID), 0);
        checkOutput("busy_after_last", int'(BUSY), 0);
    endtask

    // Main sequence: reset checks, table of lines, mid-readout reset, recapture.
    initial begin
        line_vec_t v;
        total    = 0;
        bad      = 0;
        FPGA_RST = 1'b1;
        EOC_EDGE = 1'b0;
        EOS_EDGE = 1'b0;
        ADC_DATA = '0;
        ARM      = 1'b0;
        M_READY  = 1'b0;

        vecs[0] = '{1024, 1'b0, 1'b0, 0, 1024, 1'b0};
        vecs[1] = '{1030, 1'b0, 1'b0, 0, 1024, 1'b1};
        vecs[2] = '{5,    1'b1, 1'b0, 1, 5,    1'b0};
        vecs[3] = '{64,   1'b0, 1'b1, 1, 64,   1'b0};
        vecs[4] = '{3,    1'b0, 1'b1, 2, 3,    1'b0};
        vecs[5] = '{0,    1'b0, 1'b0, 0, 0,    1'b0};
        vecs[6] = '{1025, 1'b1, 1'b0, 1, 1024, 1'b1};
        vecs[7] = '{1,    1'b1, 1'b0, 1, 1,    1'b0};

        repeat (3) @(negedge FPGA_CLK);
        checkOutput("rst_valid", int'(M_VALID), 0);
        checkOutput("rst_busy", int'(BUSY), 0);
        checkOutput("rst_ovf", int'(OVF), 0);
        checkOutput("rst_last", int'(M_LAST), 0);
        checkOutput("rst_data", int'(M_DATA), 0);
        checkOutput("rst_addr", int'(M_ADDR), 0);
        checkOutput("rst_pix_count", int'(PIX_COUNT), 0);
        FPGA_RST = 1'b0;

        EOC_EDGE = 1'b1;
        EOS_EDGE = 1'b1;
        @(negedge FPGA_CLK);
        EOC_EDGE = 1'b0;
        EOS_EDGE = 1'b0;
        checkOutput("idle_ignores_sensor", int'(BUSY), 0);
        @(negedge FPGA_CLK);

        for (int k = 0; k < 8; k++) begin
            $display("[TB] line %0d: n=%0d coinc=%0d rand_ready=%0d", k, vecs[k].n,
                     vecs[k].coinc, vecs[k].rand_ready);
            applyStimulus(vecs[k]);
            runReadout(vecs[k]);
            @(negedge FPGA_CLK);
        end

        $display("[TB] reset during readout");
        v = '{16, 1'b0, 1'b0, 1, 16, 1'b0};
        applyStimulus(v);
        M_READY = 1'b0;
        repeat (4) @(negedge FPGA_CLK);
        checkOutput("stall_valid", int'(M_VALID), 1);
        checkOutput("stall_addr", int'(M_ADDR), 0);
        checkOutput("stall_data", int'(M_DATA), exp_mem[0]);
        #2 FPGA_RST = 1'b1;
        #1;
        checkOutput("midrst_valid", int'(M_VALID), 0);
        checkOutput("midrst_busy", int'(BUSY), 0);
        checkOutput("midrst_last", int'(M_LAST), 0);
        checkOutput("midrst_pix_count", int'(PIX_COUNT), 0);
        @(negedge FPGA_CLK);
        FPGA_RST = 1'b0;
        @(negedge FPGA_CLK);

        v = '{40, 1'b0, 1'b1, 0, 40, 1'b0};
        applyStimulus(v);
        runReadout(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_capture.md
LINE_CAPTURE -- requirements
Module: line_capture

Interface
REQ-001 The block SHALL expose parameter NPIX, default 1024, meaning pixels per sensor line (buffer depth).
REQ-002 The block SHALL expose parameter DW, default 12, meaning ADC sample width in bits.
REQ-003 The block SHALL expose parameter DARK_LEVEL, default 0, meaning DW-bit offset subtracted when DARK_SUB_EN is defined.
REQ-004 The block SHALL have port FPGA_CLK  input  1  the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port FPGA_RST  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port EOC_EDGE  input  1  one-cycle pulse per sensor end-of-conversion (pixel valid).
REQ-007 The block SHALL have port EOS_EDGE  input  1  one-cycle pulse per sensor end-of-scan (line boundary).
REQ-008 The block SHALL have port ADC_DATA  input  DW  pixel sample, valid in the cycle EOC_EDGE is high.
REQ-009 The block SHALL have port ARM  input  1  level request to capture the next complete line.
REQ-010 The block SHALL have port M_VALID  output  1  readout stream data valid.
REQ-011 The block SHALL have port M_READY  input  1  readout stream consumer ready.
REQ-012 The block SHALL have port M_DATA  output  DW  readout pixel value.
REQ-013 The block SHALL have port M_ADDR  output  clog2(NPIX)  readout pixel index.
REQ-014 The block SHALL have port M_LAST  output  1  high with the final pixel of the line.
REQ-015 The block SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port OVF  output  1  sticky flag: more than NPIX EOC pulses in a line.
REQ-017 The block SHALL have port PIX_COUNT  output  clog2(NPIX)+1  pixels stored in the last captured line.

Function
REQ-018 The FSM SHALL have states IDLE, SYNC, CAPTURE and READOUT.
REQ-019 IDLE->SYNC SHALL occur the cycle after ARM is sampled high; ARM outside IDLE SHALL be ignored.
REQ-020 Entering SYNC SHALL clear OVF and the write pointer; EOC_EDGE in SYNC SHALL be ignored.
REQ-021 SYNC->CAPTURE SHALL occur on EOS_EDGE, so capture always starts at a line boundary.
REQ-022 In CAPTURE, each EOC_EDGE SHALL write ADC_DATA to buffer[wr_ptr] and increment wr_ptr by 1.
REQ-023 EOC_EDGE with wr_ptr == NPIX SHALL NOT write, SHALL NOT wrap the pointer, and SHALL set OVF.
REQ-024 EOS_EDGE in CAPTURE SHALL latch PIX_COUNT = wr_ptr and move to READOUT, or to IDLE if wr_ptr == 0.
REQ-025 EOC_EDGE and EOS_EDGE in the same CAPTURE cycle SHALL store the pixel first; PIX_COUNT SHALL include it.
REQ-026 READOUT SHALL present addresses 0..PIX_COUNT-1 in order, with M_VALID first asserted 2 cycles after entry (synchronous RAM read).
REQ-027 A transfer SHALL complete when M_VALID && M_READY; M_DATA, M_ADDR and M_LAST SHALL hold while M_VALID && !M_READY.
REQ-028 After the M_LAST transfer, M_VALID SHALL drop in the next cycle and the FSM SHALL return to IDLE.
REQ-029 EOC_EDGE and EOS_EDGE SHALL be ignored in IDLE and READOUT; a line arriving during READOUT is dropped.
REQ-030 Stream throughput SHALL be one pixel per cycle while M_READY is held high.

Reset
REQ-031 FPGA_RST high SHALL immediately force IDLE, with M_VALID, M_LAST, BUSY and OVF at 0, M_DATA and M_ADDR at 0, and PIX_COUNT at 0.
REQ-032 Reset asserted mid-CAPTURE or mid-READOUT SHALL abandon the line; buffer contents SHALL be treated as undefined and SHALL NOT be reset.
REQ-033 The first ARM after reset release SHALL behave identically to the first ARM after power-up.

Configuration
REQ-034 With macro LINE_CAPTURE_DARK_SUB_EN defined, the stored value SHALL be max(ADC_DATA - DARK_LEVEL, 0), computed in DW+1 bits and saturated at 0.
REQ-035 Without LINE_CAPTURE_DARK_SUB_EN, ADC_DATA SHALL be stored unmodified and DARK_LEVEL SHALL have no effect.

Verification
REQ-036 Check: ARM; EOS; 1024 EOC with ADC_DATA=index; EOS -> PIX_COUNT=1024, 1024 beats with M_DATA=M_ADDR, M_LAST on beat 1023, OVF=0.
REQ-037 Check: 1030 EOC in one line -> OVF=1, PIX_COUNT=1024, last beat data=1023, no address wrap.
REQ-038 Check: M_READY toggled by a random 50% pattern during readout -> no lost or duplicated beats; outputs stable while stalled.
REQ-039 Check: the 5th EOC coincides with EOS -> PIX_COUNT=5 and beat 4 carries the 5th sample.
REQ-040 Check: FPGA_RST pulsed mid-READOUT -> M_VALID=0 and BUSY=0 the same cycle; a new ARM/line then captures correctly.
REQ-041 Check: with DARK_SUB_EN defined and DARK_LEVEL=100, inputs 50/100/4095 -> outputs 0/0/3995.
